// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the multiplier self-test sequencer.
// The LFSR step function is shared by the vector generator and the optional MISR.
package mul_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRIVE,
      S_SETTLE,
      S_CHECK,
      S_FINISH
   } seqState_e;

   localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
   localparam logic [31:0] LFSR_NONZERO_SEED = 32'h0000_0001;
   localparam logic [31:0] MISR_INIT         = 32'h0000_0000;

   // Galois right-shift step: the bit shifted out folds the tap mask back in.
   function automatic logic [31:0] lfsrNext(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/mul_seq_lfsr.sv
// 32-bit Galois LFSR with parallel load and an optional data input folded into
// each step, so the same block serves as the vector generator and as a MISR.
module mul_seq_lfsr
   import mul_seq_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        en_i,
   input  logic [31:0] seed_i,
   input  logic [31:0] data_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   // Load has priority over a step so a fresh run always starts from its seed.
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = seed_i;
      end else if (en_i) begin
         state_d = lfsrNext(state_q) ^ data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= 32'h0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/mul_test_sequencer.sv
// Self-test sequencer for a 16x16 unsigned multiplier: LFSR vectors, golden
// compare, mismatch count and first-fail capture. MUL_SEQ_MISR_EN adds a MISR signature.
module mul_test_sequencer
   import mul_seq_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      seed_i,
   input  logic [CNT_W-1:0] num_vectors_i,
   output logic [31:0]      dut_in_o,
   input  logic [31:0]      dut_out_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] vec_idx_o,
   output logic [CNT_W-1:0] mismatch_cnt_o,
   output logic             fail_flag_o,
   output logic [31:0]      first_fail_in_o,
   output logic [31:0]      first_fail_out_o
`ifdef MUL_SEQ_MISR_EN
   ,
   output logic [31:0]      signature_o
`endif
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   seqState_e        state_q, state_d;
   logic [31:0]      seed_q, seed_d;
   logic [CNT_W-1:0] nvec_q, nvec_d;
   logic [31:0]      dutIn_q, dutIn_d;
   logic [CNT_W-1:0] vecIdx_q, vecIdx_d;
   logic [CNT_W-1:0] mismatchCnt_q, mismatchCnt_d;
   logic             failFlag_q, failFlag_d;
   logic [31:0]      firstFailIn_q, firstFailIn_d;
   logic [31:0]      firstFailOut_q, firstFailOut_d;
   logic [SW-1:0]    settleCnt_q, settleCnt_d;

   logic             lfsrLoad;
   logic             lfsrEn;
   logic             runClear;
   logic [31:0]      lfsrSeed;
   logic [31:0]      lfsrState;
   logic [31:0]      expected;

   // A zero seed would lock the LFSR, so it is replaced by a fixed nonzero one.
   assign lfsrSeed = (seed_q == 32'h0) ? LFSR_NONZERO_SEED : seed_q;
   assign expected = dutIn_q[31:16] * dutIn_q[15:0];

   mul_seq_lfsr u_lfsr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (lfsrLoad),
      .en_i    (lfsrEn),
      .seed_i  (lfsrSeed),
      .data_i  (32'h0),
      .state_o (lfsrState)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath: every register holds unless its state touches it.
   always_comb begin
      state_d        = state_q;
      seed_d         = seed_q;
      nvec_d         = nvec_q;
      dutIn_d        = dutIn_q;
      vecIdx_d       = vecIdx_q;
      mismatchCnt_d  = mismatchCnt_q;
      failFlag_d     = failFlag_q;
      firstFailIn_d  = firstFailIn_q;
      firstFailOut_d = firstFailOut_q;
      settleCnt_d    = settleCnt_q;
      lfsrLoad       = 1'b0;
      lfsrEn         = 1'b0;
      runClear       = 1'b0;

      case (state_q)
         S_IDLE, S_FINISH: begin
            if (start_i) begin
               runClear       = 1'b1;
               seed_d         = seed_i;
               nvec_d         = num_vectors_i;
               vecIdx_d       = '0;
               mismatchCnt_d  = '0;
               failFlag_d     = 1'b0;
               firstFailIn_d  = 32'h0;
               firstFailOut_d = 32'h0;
               state_d        = S_LOAD;
            end
         end
         S_LOAD: begin
            lfsrLoad = 1'b1;
            state_d  = (nvec_q == '0) ? S_FINISH : S_DRIVE;
         end
         S_DRIVE: begin
            dutIn_d     = lfsrState;
            settleCnt_d = '0;
            state_d     = S_SETTLE;
         end
         S_SETTLE: begin
            if (settleCnt_q == SW'(SETTLE_CYC - 1)) begin
               state_d = S_CHECK;
            end else begin
               settleCnt_d = settleCnt_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (dut_out_i != expected) begin
               if (mismatchCnt_q != '1) begin
                  mismatchCnt_d = mismatchCnt_q + 1'b1;
               end
               if (!failFlag_q) begin
                  failFlag_d     = 1'b1;
                  firstFailIn_d  = dutIn_q;
                  firstFailOut_d = dut_out_i;
               end
            end
            lfsrEn   = 1'b1;
            vecIdx_d = vecIdx_q + 1'b1;
            state_d  = (vecIdx_d == nvec_q) ? S_FINISH : S_DRIVE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seed_q         <= 32'h0;
         nvec_q         <= '0;
         dutIn_q        <= 32'h0;
         vecIdx_q       <= '0;
         mismatchCnt_q  <= '0;
         failFlag_q     <= 1'b0;
         firstFailIn_q  <= 32'h0;
         firstFailOut_q <= 32'h0;
         settleCnt_q    <= '0;
      end else begin
         seed_q         <= seed_d;
         nvec_q         <= nvec_d;
         dutIn_q        <= dutIn_d;
         vecIdx_q       <= vecIdx_d;
         mismatchCnt_q  <= mismatchCnt_d;
         failFlag_q     <= failFlag_d;
         firstFailIn_q  <= firstFailIn_d;
         firstFailOut_q <= firstFailOut_d;
         settleCnt_q    <= settleCnt_d;
      end
   end

   // An empty run never asserts busy; LOAD only counts as busy when vectors follow.
   assign busy_o = ((state_q == S_LOAD) && (nvec_q != '0)) ||
                   (state_q == S_DRIVE) || (state_q == S_SETTLE) ||
                   (state_q == S_CHECK);
   assign done_o           = (state_q == S_FINISH);
   assign dut_in_o         = dutIn_q;
   assign vec_idx_o        = vecIdx_q;
   assign mismatch_cnt_o   = mismatchCnt_q;
   assign fail_flag_o      = failFlag_q;
   assign first_fail_in_o  = firstFailIn_q;
   assign first_fail_out_o = firstFailOut_q;

`ifdef MUL_SEQ_MISR_EN
   // The MISR folds every sampled product into the signature, one step per CHECK.
   mul_seq_lfsr u_misr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (runClear),
      .en_i    (state_q == S_CHECK),
      .seed_i  (MISR_INIT),
      .data_i  (dut_out_i),
      .state_o (signature_o)
   );
`else
   logic unusedRunClear;
   assign unusedRunClear = runClear;
`endif

endmodule

// File: tb/tb_mul_test_sequencer.sv
// Directed bench for mul_test_sequencer with a behavioural multiplier that can
// inject faults; a second instance with CNT_W=4 exercises the narrow counter.
module tb_mul_test_sequencer;

   localparam logic [31:0] POLY = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        startA = 1'b0;
   logic [31:0] seedA  = 32'h0;
   logic [15:0] numA   = 16'h0;
   logic [31:0] dutInA, dutOutA;
   logic        busyA, doneA, failA;
   logic [15:0] vecIdxA, mismA;
   logic [31:0] ffInA, ffOutA;

   logic        startB = 1'b0;
   logic [31:0] seedB  = 32'h0;
   logic [3:0]  numB   = 4'h0;
   logic [31:0] dutInB, dutOutB;
   logic        busyB, doneB, failB;
   logic [3:0]  vecIdxB, mismB;
   logic [31:0] ffInB, ffOutB;

`ifdef MUL_SEQ_MISR_EN
   logic [31:0] sigA, sigB;
`endif

   int mode = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Behavioural multiplier: 0 golden, 1 flip bit 0 when a==DEAD, 2 stuck at 0, 3 inverted.
   always_comb begin
      logic [31:0] p;
      p = {16'h0, dutInA[31:16]} * {16'h0, dutInA[15:0]};
      case (mode)
         1:       dutOutA = (dutInA[31:16] == 16'hDEAD) ? (p ^ 32'h1) : p;
         2:       dutOutA = 32'h0;
         3:       dutOutA = ~p;
         default: dutOutA = p;
      endcase
   end

   assign dutOutB = ~({16'h0, dutInB[31:16]} * {16'h0, dutInB[15:0]});

   mul_test_sequencer #(.SETTLE_CYC(4), .CNT_W(16)) dutA (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (startA),
      .seed_i           (seedA),
      .num_vectors_i    (numA),
      .dut_in_o         (dutInA),
      .dut_out_i        (dutOutA),
      .busy_o           (busyA),
      .done_o           (doneA),
      .vec_idx_o        (vecIdxA),
      .mismatch_cnt_o   (mismA),
      .fail_flag_o      (failA),
      .first_fail_in_o  (ffInA),
      .first_fail_out_o (ffOutA)
`ifdef MUL_SEQ_MISR_EN
      ,
      .signature_o      (sigA)
`endif
   );

   mul_test_sequencer #(.SETTLE_CYC(1), .CNT_W(4)) dutB (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (startB),
      .seed_i           (seedB),
      .num_vectors_i    (numB),
      .dut_in_o         (dutInB),
      .dut_out_i        (dutOutB),
      .busy_o           (busyB),
      .done_o           (doneB),
      .vec_idx_o        (vecIdxB),
      .mismatch_cnt_o   (mismB),
      .fail_flag_o      (failB),
      .first_fail_in_o  (ffInB),
      .first_fail_out_o (ffOutB)
`ifdef MUL_SEQ_MISR_EN
      ,
      .signature_o      (sigB)
`endif
   );

   function automatic logic [31:0] stepFwd(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ POLY;
      return n;
   endfunction

   // Inverse step: the top bit of the next state reveals the bit shifted out.
   function automatic logic [31:0] stepBack(input logic [31:0] n);
      logic        s0;
      logic [31:0] t;
      s0 = n[31];
      t  = s0 ? (n ^ POLY) : n;
      return {t[30:0], s0};
   endfunction

   task automatic startRunA(input logic [31:0] s, input logic [15:0] n);
      @(negedge clk);
      seedA  = s;
      numA   = n;
      startA = 1'b1;
      @(posedge clk);
      #1;
      startA = 1'b0;
   endtask

   // Counts edges after the start edge until done, bounded; flags a timeout.
   task automatic waitDoneA(input int limit, output int cycles, output bit busySeen,
                            output logic [31:0] dutIn2);
      cycles   = 0;
      busySeen = busyA;
      dutIn2   = 32'h0;
      while (!doneA && cycles < limit) begin
         @(posedge clk);
         #1;
         cycles++;
         if (busyA) busySeen = 1'b1;
         if (cycles == 2) dutIn2 = dutInA;
      end
      checks++;
      if (!doneA) begin
         errors++;
         $display("[TB] FAIL timeout: done=%0b after %0d cycles, required done=1", doneA, cycles);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busyA, doneA, failA} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: busy/done/fail=%b required 000", {busyA, doneA, failA});
      end
      checks++;
      if ({dutInA, vecIdxA, mismA, ffInA, ffOutA} !== 128'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: dut_in=%h vec_idx=%h mism=%h ffin=%h ffout=%h required all 0",
                  dutInA, vecIdxA, mismA, ffInA, ffOutA);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_golden();
      int cycles;
      bit busySeen;
      logic [31:0] d2;
      mode = 0;
      startRunA(32'h1, 16'd8);
      waitDoneA(300, cycles, busySeen, d2);
      checks++;
      if (cycles !== 49) begin
         errors++;
         $display("[TB] FAIL golden_latency: cycles=%0d required 49", cycles);
      end
      checks++;
      if (d2 !== 32'h1) begin
         errors++;
         $display("[TB] FAIL golden_first_vec: dut_in=%h required 00000001", d2);
      end
      checks++;
      if (mismA !== 16'd0 || failA !== 1'b0 || busyA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL golden_result: mism=%0d fail=%0b busy=%0b required 0 0 0", mismA, failA, busyA);
      end
   endtask

   task automatic test_dead_vector();
      int cycles, expMism;
      bit busySeen;
      logic [31:0] d2, s, v, expOut;
      mode = 1;
      s = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) s = stepBack(s);
      expMism = 0;
      v = s;
      for (int i = 0; i < 8; i++) begin
         if (v[31:16] == 16'hDEAD) expMism++;
         v = stepFwd(v);
      end
      expOut = (32'h0000_DEAD * 32'h0000_BEEF) ^ 32'h1;
      startRunA(s, 16'd8);
      waitDoneA(300, cycles, busySeen, d2);
      checks++;
      if (mismA !== 16'(expMism) || failA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dead_count: mism=%0d fail=%0b required %0d 1", mismA, failA, expMism);
      end
      checks++;
      if (ffInA !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL dead_ffin: first_fail_in=%h required deadbeef", ffInA);
      end
      checks++;
      if (ffOutA !== expOut) begin
         errors++;
         $display("[TB] FAIL dead_ffout: first_fail_out=%h required %h", ffOutA, expOut);
      end
   endtask

   task automatic test_zero_vectors();
      int cycles;
      bit busySeen;
      logic [31:0] d2;
      mode = 3;
      startRunA(32'h1234_5678, 16'd0);
      waitDoneA(20, cycles, busySeen, d2);
      checks++;
      if (cycles !== 1) begin
         errors++;
         $display("[TB] FAIL zero_latency: cycles=%0d required 1", cycles);
      end
      checks++;
      if (busySeen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_busy: busy seen=%0b required 0", busySeen);
      end
      checks++;
      if (mismA !== 16'd0 || failA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_counts: mism=%0d fail=%0b required 0 0", mismA, failA);
      end
   endtask

   task automatic test_zero_seed();
      int cycles, expMism;
      bit busySeen, seenFail;
      logic [31:0] d2, v, expFfIn;
      mode = 2;
      expMism  = 0;
      seenFail = 1'b0;
      expFfIn  = 32'h0;
      v = 32'h1;
      for (int i = 0; i < 4; i++) begin
         if ((v[31:16] * v[15:0]) != 0) begin
            expMism++;
            if (!seenFail) expFfIn = v;
            seenFail = 1'b1;
         end
         v = stepFwd(v);
      end
      startRunA(32'h0, 16'd4);
      waitDoneA(300, cycles, busySeen, d2);
      checks++;
      if (d2 !== 32'h1) begin
         errors++;
         $display("[TB] FAIL zseed_first_vec: dut_in=%h required 00000001", d2);
      end
      checks++;
      if (mismA !== 16'(expMism)) begin
         errors++;
         $display("[TB] FAIL zseed_count: mism=%0d required %0d", mismA, expMism);
      end
      checks++;
      if (ffInA !== expFfIn || ffOutA !== 32'h0) begin
         errors++;
         $display("[TB] FAIL zseed_ffin: ffin=%h ffout=%h required %h 00000000", ffInA, ffOutA, expFfIn);
      end
   endtask

   task automatic test_reset_midrun();
      int cycles, w;
      bit busySeen;
      logic [31:0] d2;
      mode = 3;
      startRunA(32'h1, 16'd20);
      w = 0;
      while (vecIdxA !== 16'd5 && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      checks++;
      if (vecIdxA !== 16'd5) begin
         errors++;
         $display("[TB] FAIL midrst_reach: vec_idx=%0d required 5", vecIdxA);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({busyA, doneA, failA} !== 3'b000 ||
          {dutInA, vecIdxA, mismA, ffInA, ffOutA} !== 128'h0) begin
         errors++;
         $display("[TB] FAIL midrst_clear: busy=%0b done=%0b fail=%0b dut_in=%h idx=%0d mism=%0d required all 0",
                  busyA, doneA, failA, dutInA, vecIdxA, mismA);
      end
      @(negedge clk);
      rst  = 1'b0;
      mode = 0;
      startRunA(32'h1, 16'd8);
      waitDoneA(300, cycles, busySeen, d2);
      checks++;
      if (cycles !== 49 || mismA !== 16'd0 || failA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_rerun: cycles=%0d mism=%0d fail=%0b required 49 0 0", cycles, mismA, failA);
      end
   endtask

   task automatic test_start_while_busy();
      int cycles, extra;
      bit busySeen;
      logic [31:0] d2, s;
      mode = 1;
      s = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) s = stepBack(s);
      startRunA(s, 16'd8);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      seedA  = 32'h1;
      numA   = 16'd2;
      startA = 1'b1;
      @(posedge clk);
      #1;
      startA = 1'b0;
      waitDoneA(300, extra, busySeen, d2);
      cycles = 11 + extra;
      checks++;
      if (cycles !== 49) begin
         errors++;
         $display("[TB] FAIL busy_start_latency: cycles=%0d required 49", cycles);
      end
      checks++;
      if (mismA !== 16'd1 || ffInA !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL busy_start_result: mism=%0d ffin=%h required 1 deadbeef", mismA, ffInA);
      end
   endtask

   task automatic test_saturation();
      int cycles;
      @(negedge clk);
      seedB  = 32'hACE1_2345;
      numB   = 4'hF;
      startB = 1'b1;
      @(posedge clk);
      #1;
      startB = 1'b0;
      cycles = 0;
      while (!doneB && cycles < 300) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checks++;
      if (doneB !== 1'b1 || cycles !== 46) begin
         errors++;
         $display("[TB] FAIL narrow_latency: done=%0b cycles=%0d required 1 46", doneB, cycles);
      end
      checks++;
      if (mismB !== 4'hF || failB !== 1'b1 || ffInB !== 32'hACE1_2345) begin
         errors++;
         $display("[TB] FAIL narrow_count: mism=%h fail=%0b ffin=%h required f 1 ace12345", mismB, failB, ffInB);
      end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_dead_vector();
      test_zero_vectors();
      test_zero_seed();
      test_reset_midrun();
      test_start_while_busy();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
